// File: rtl/bitonic_sort_pipe_pkg.sv
// Shared helpers for the pipelined bitonic sorter: lane/stage counts and the
// mapping from a flat network column index to its bitonic (p, q) coordinates.
package sort_pkg;

    // Lane count N = 2**log2n.
    function automatic int lanes(input int log2n);
        return 1 << log2n;
    endfunction

    // Number of network columns (and pipeline stages) for 2**log2n lanes.
    function automatic int stage_count(input int log2n);
        return (log2n * (log2n + 1)) / 2;
    endfunction

    // Merge level p of column k; columns run p = 1..log2n, q = p..1.
    function automatic int col_p(input int k, input int log2n);
        int idx = 0;
        int res = 1;
        for (int p = 1; p <= log2n; p++) begin
            for (int q = p; q >= 1; q--) begin
                if (idx == k) res = p;
                idx++;
            end
        end
        return res;
    endfunction

    // Sub-step q of column k; the column pairs lanes whose index differs in bit q-1.
    function automatic int col_q(input int k, input int log2n);
        int idx = 0;
        int res = 1;
        for (int p = 1; p <= log2n; p++) begin
            for (int q = p; q >= 1; q--) begin
                if (idx == k) res = q;
                idx++;
            end
        end
        return res;
    endfunction

    // Low lane of the j-th pair in a column with sub-step q: j with a zero
    // inserted at bit position q-1.
    function automatic int low_lane(input int j, input int q);
        return ((j >> (q - 1)) << q) | (j & ((1 << (q - 1)) - 1));
    endfunction

endpackage

// File: rtl/bitonic_sort_pipe_cmp_swap.sv
// Combinational compare-exchange element. dir = 0 puts the minimum on lo,
// dir = 1 puts the maximum on lo. Equal keys are passed through unswapped.
module cmp_swap #(
    parameter int W      = 32,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         dir,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic a_lt_b;
    logic b_lt_a;
    logic swap;

    generate
        if (SIGNED != 0) begin : g_signed
            assign a_lt_b = $signed(a) < $signed(b);
            assign b_lt_a = $signed(b) < $signed(a);
        end else begin : g_unsigned
            assign a_lt_b = a < b;
            assign b_lt_a = b < a;
        end
    endgenerate

    // Strict comparisons only, so ties never swap.
    assign swap = dir ? a_lt_b : b_lt_a;
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorting network: one register per network column,
// valid/ready flow control with bubble collapse, per-vector sort direction.
module bitonic_sort_pipe
    import sort_pkg::*;
#(
    parameter  int W      = 32,
    parameter  int LOG2N  = 2,
    parameter  int SIGNED = 0,
    localparam int N      = lanes(LOG2N),
    localparam int S      = stage_count(LOG2N),
    localparam int OW     = $clog2(S + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic          in_desc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N*W-1:0] out_data,
    output logic          out_desc,
    output logic [OW-1:0] occupancy
);

    logic [N*W-1:0] data_reg [S];
    logic [S-1:0]   valid_reg;
    logic [S-1:0]   desc_reg;
    logic [OW-1:0]  occ_reg;

    logic [N*W-1:0] col_in  [S];
    logic [N*W-1:0] col_out [S];
    logic [S-1:0]   col_valid;
    logic [S-1:0]   col_desc;
    logic [S-1:0]   adv;
    logic [S-1:0]   valid_next;
    logic [OW-1:0]  occ_next;

    // Column k consumes the inputs (k = 0) or the previous stage register.
    always_comb begin
        col_in[0]    = in_data;
        col_valid    = '0;
        col_desc     = '0;
        col_valid[0] = in_valid;
        col_desc[0]  = in_desc;
        for (int k = 1; k < S; k++) begin
            col_in[k]    = data_reg[k-1];
            col_valid[k] = valid_reg[k-1];
            col_desc[k]  = desc_reg[k-1];
        end
    end

    // Advance chain from the output back to stage 0: a stage may load when it
    // is empty or when everything downstream of it is moving.
    always_comb begin
        logic chain;
        adv   = '0;
        chain = !valid_reg[S-1] | out_ready;
        adv[S-1] = chain;
        for (int k = S - 2; k >= 0; k--) begin
            chain  = !valid_reg[k] | chain;
            adv[k] = chain;
        end
    end

    // Next valid pattern and its popcount, so occupancy tracks the valid bits.
    always_comb begin
        valid_next = '0;
        occ_next   = '0;
        for (int k = 0; k < S; k++) begin
            valid_next[k] = adv[k] ? col_valid[k] : valid_reg[k];
            occ_next      = occ_next + OW'(valid_next[k]);
        end
    end

    // Compare-exchange array: S columns of N/2 elements each.
    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_col
            localparam int P = col_p(gi, LOG2N);
            localparam int Q = col_q(gi, LOG2N);
            for (genvar gj = 0; gj < N / 2; gj++) begin : g_pair
                localparam int LO = low_lane(gj, Q);
                localparam int HI = LO + (1 << (Q - 1));
                // Bit p of the lane index selects the merge direction; on the
                // final level (p = LOG2N) LO < N so the bit is naturally 0.
                localparam logic BLK = ((LO >> P) & 1) != 0;
                logic dir;
                assign dir = BLK ^ col_desc[gi];
                cmp_swap #(
                    .W      (W),
                    .SIGNED (SIGNED)
                ) u_cs (
                    .a   (col_in[gi][LO*W +: W]),
                    .b   (col_in[gi][HI*W +: W]),
                    .dir (dir),
                    .lo  (col_out[gi][LO*W +: W]),
                    .hi  (col_out[gi][HI*W +: W])
                );
            end
        end
    endgenerate

    // Stage registers: load on advance; data only captured behind a valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= '0;
            desc_reg  <= '0;
            occ_reg   <= '0;
            for (int k = 0; k < S; k++) begin
                data_reg[k] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            occ_reg   <= occ_next;
            for (int k = 0; k < S; k++) begin
                if (adv[k]) begin
                    desc_reg[k] <= col_desc[k];
                    if (col_valid[k]) begin
                        data_reg[k] <= col_out[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_reg[S-1];
    assign out_data  = data_reg[S-1];
    assign out_desc  = desc_reg[S-1];
    assign occupancy = occ_reg;

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Scoreboard bench for bitonic_sort_pipe: directed N=4 cases, signed/unsigned
// 8-bit extremes, and a randomized N=8 stream against a plain sorting model.
module tb_bitonic_sort_pipe;

    localparam int SA = 3;
    localparam int SC = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: N=4, W=32, unsigned
    logic         in_valid_a, in_ready_a, in_desc_a, out_valid_a, out_ready_a, out_desc_a;
    logic [127:0] in_data_a, out_data_a;
    logic [1:0]   occ_a;
    // DUT C: N=8, W=16, signed
    logic         in_valid_c, in_ready_c, in_desc_c, out_valid_c, out_ready_c, out_desc_c;
    logic [127:0] in_data_c, out_data_c;
    logic [2:0]   occ_c;
    // DUT S / U: N=4, W=8, signed and unsigned, shared stimulus
    logic         in_valid_s, in_desc_s, out_ready_s;
    logic [31:0]  in_data_s;
    logic         in_ready_s, out_valid_s, out_desc_s, in_ready_u, out_valid_u, out_desc_u;
    logic [31:0]  out_data_s, out_data_u;
    logic [1:0]   occ_s, occ_u;

    bitonic_sort_pipe #(.W(32), .LOG2N(2), .SIGNED(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .in_desc(in_desc_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_desc(out_desc_a),
        .occupancy(occ_a));
    bitonic_sort_pipe #(.W(16), .LOG2N(3), .SIGNED(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_data(in_data_c), .in_desc(in_desc_c), .out_valid(out_valid_c),
        .out_ready(out_ready_c), .out_data(out_data_c), .out_desc(out_desc_c),
        .occupancy(occ_c));
    bitonic_sort_pipe #(.W(8), .LOG2N(2), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_data(in_data_s), .in_desc(in_desc_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s), .out_data(out_data_s), .out_desc(out_desc_s),
        .occupancy(occ_s));
    bitonic_sort_pipe #(.W(8), .LOG2N(2), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_u),
        .in_data(in_data_s), .in_desc(in_desc_s), .out_valid(out_valid_u),
        .out_ready(out_ready_s), .out_data(out_data_u), .out_desc(out_desc_u),
        .occupancy(occ_u));

    typedef struct {
        logic [127:0] data;
        logic         desc;
        int           cyc;
        bit           strict;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_c[$];
    exp_t ea, ec, pa, pc;
    int   passed = 0;
    int   total  = 0;
    int   acc_c  = 0;
    bit   armed  = 0;
    bit   strict_a = 1;
    bit   strict_c = 1;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: extract keys, sort ascending numerically, reverse for descending.
    function automatic logic [127:0] ref_sort(input logic [127:0] v, input int n, input int w,
                                              input bit sgn, input logic d);
        longint k[32];
        longint t;
        longint m = (longint'(1) << w) - 1;
        logic [127:0] r = '0;
        for (int i = 0; i < n; i++) begin
            k[i] = longint'(v >> (i * w)) & m;
            if (sgn && ((k[i] >> (w - 1)) & 1) != 0) k[i] = k[i] - (longint'(1) << w);
        end
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (k[j] < k[i]) begin t = k[i]; k[i] = k[j]; k[j] = t; end
        for (int i = 0; i < n; i++)
            r = r | (128'(k[d ? n - 1 - i : i] & m) << (i * w));
        return r;
    endfunction

    // Issue side: log every accepted vector with its expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_a.delete();
            sb_c.delete();
        end else begin
            if (in_valid_a && in_ready_a) begin
                ea.data = ref_sort(in_data_a, 4, 32, 0, in_desc_a);
                ea.desc = in_desc_a; ea.cyc = cyc; ea.strict = strict_a;
                sb_a.push_back(ea);
            end
            if (in_valid_c && in_ready_c) begin
                ec.data = ref_sort(in_data_c, 8, 16, 1, in_desc_c);
                ec.desc = in_desc_c; ec.cyc = cyc; ec.strict = strict_c;
                sb_c.push_back(ec);
                acc_c++;
            end
        end
    end

    // Output monitors: compare each delivered vector and stall stability.
    logic [127:0] hold_data_a, hold_data_c;
    logic         hold_desc_a, hold_desc_c;
    bit           stall_a = 0, stall_c = 0;

    always @(negedge clk) begin
        if (!rst_n) stall_a = 0;
        else begin
            if (stall_a) begin
                chk(out_valid_a, "hold_valid_a", 128'(out_valid_a), 1);
                chk(out_data_a == hold_data_a && out_desc_a == hold_desc_a, "hold_data_a", out_data_a, hold_data_a);
            end
            if (out_valid_a && out_ready_a) begin
                if (sb_a.size() == 0) chk(0, "unexpected_out_a", out_data_a, 0);
                else begin
                    pa = sb_a.pop_front();
                    chk(out_data_a == pa.data, "data_a", out_data_a, pa.data);
                    chk(out_desc_a == pa.desc, "desc_a", 128'(out_desc_a), 128'(pa.desc));
                    if (pa.strict) chk(cyc - pa.cyc == SA, "latency_a", 128'(cyc - pa.cyc), SA);
                    else           chk(cyc - pa.cyc >= SA, "min_latency_a", 128'(cyc - pa.cyc), SA);
                    $display("a out %h desc %0d latency %0d", out_data_a, out_desc_a, cyc - pa.cyc);
                end
            end
            stall_a = out_valid_a && !out_ready_a;
            hold_data_a = out_data_a;
            hold_desc_a = out_desc_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) stall_c = 0;
        else begin
            if (stall_c) begin
                chk(out_valid_c, "hold_valid_c", 128'(out_valid_c), 1);
                chk(out_data_c == hold_data_c && out_desc_c == hold_desc_c, "hold_data_c", out_data_c, hold_data_c);
            end
            if (out_valid_c && out_ready_c) begin
                if (sb_c.size() == 0) chk(0, "unexpected_out_c", out_data_c, 0);
                else begin
                    pc = sb_c.pop_front();
                    chk(out_data_c == pc.data, "data_c", out_data_c, pc.data);
                    chk(out_desc_c == pc.desc, "desc_c", 128'(out_desc_c), 128'(pc.desc));
                    if (pc.strict) chk(cyc - pc.cyc == SC, "latency_c", 128'(cyc - pc.cyc), SC);
                    else           chk(cyc - pc.cyc >= SC, "min_latency_c", 128'(cyc - pc.cyc), SC);
                    $display("c out %h desc %0d latency %0d", out_data_c, out_desc_c, cyc - pc.cyc);
                end
            end
            stall_c = out_valid_c && !out_ready_c;
            hold_data_c = out_data_c;
            hold_desc_c = out_desc_c;
        end
    end

    // Occupancy must equal the number of accepted-but-undelivered vectors.
    always @(posedge clk) begin
        #2;
        if (armed && rst_n) begin
            chk(int'(occ_a) == sb_a.size(), "occ_a", 128'(occ_a), 128'(sb_a.size()));
            chk(int'(occ_c) == sb_c.size(), "occ_c", 128'(occ_c), 128'(sb_c.size()));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a vector on A until accepted (caller sits just after a rising edge).
    task automatic send_a(input logic [127:0] d, input logic ds);
        int  n = 0;
        bit  acc = 0;
        in_valid_a = 1'b1; in_data_a = d; in_desc_a = ds;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready_a;
            n++;
            if (!acc) begin @(posedge clk); #1; end
        end
        if (!acc) chk(0, "send_timeout_a", 0, 1);
        if (acc) begin @(posedge clk); #1; end
        in_valid_a = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid_a = 0; in_data_a = '0; in_desc_a = 0; out_ready_a = 0;
        in_valid_c = 0; in_data_c = '0; in_desc_c = 0; out_ready_c = 0;
        in_valid_s = 0; in_data_s = '0; in_desc_s = 0; out_ready_s = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        armed = 1;

        // Reset state
        @(negedge clk);
        chk(!out_valid_a, "rst_out_valid", 128'(out_valid_a), 0);
        chk(occ_a == 0, "rst_occ", 128'(occ_a), 0);
        chk(in_ready_a, "rst_in_ready", 128'(in_ready_a), 1);
        chk(out_data_a == 0, "rst_out_data", out_data_a, 0);
        chk(!out_desc_a, "rst_out_desc", 128'(out_desc_a), 0);
        chk(!out_valid_c && occ_c == 0 && in_ready_c, "rst_c", 128'({out_valid_c, occ_c, in_ready_c}), 1);
        chk(occ_s == 0 && occ_u == 0 && in_ready_s && in_ready_u, "rst_su", 128'({occ_s, occ_u, in_ready_s, in_ready_u}), 3);
        @(posedge clk); #1;

        // Single ascending vector {7,3,9,1}; descending with tie {5,5,2,8}
        out_ready_a = 1;
        strict_a = 1;
        send_a({32'd1, 32'd9, 32'd3, 32'd7}, 1'b0);
        idle(5);
        send_a({32'd8, 32'd2, 32'd5, 32'd5}, 1'b1);
        idle(5);

        // Back-pressure: fill while the consumer stalls, then release
        strict_a = 0;
        out_ready_a = 0;
        send_a(rnd128(), 1'b0);
        send_a(rnd128(), 1'b1);
        send_a(rnd128(), 1'b0);
        in_valid_a = 1; in_data_a = rnd128(); in_desc_a = 1;
        repeat (3) begin
            @(negedge clk);
            chk(!in_ready_a, "full_in_ready", 128'(in_ready_a), 0);
            chk(occ_a == 3, "full_occ", 128'(occ_a), 3);
            @(posedge clk); #1;
        end
        out_ready_a = 1;
        @(negedge clk);
        chk(in_ready_a, "release_in_ready", 128'(in_ready_a), 1);
        @(posedge clk); #1;
        send_a(rnd128(), 1'b0);
        idle(8);

        // Reset with two vectors in flight and a transfer offered in the reset cycle
        strict_a = 1;
        send_a(rnd128(), 1'b0);
        send_a(rnd128(), 1'b1);
        rst_n = 0; in_valid_a = 1; in_data_a = rnd128();
        @(posedge clk); #1;
        rst_n = 1; in_valid_a = 0;
        @(negedge clk);
        chk(!out_valid_a, "midrst_out_valid", 128'(out_valid_a), 0);
        chk(occ_a == 0, "midrst_occ", 128'(occ_a), 0);
        idle(8);

        // Signed vs unsigned 8-bit extremes: lanes {80,7F,FF,00}
        out_ready_s = 1; in_desc_s = 0;
        in_data_s = {8'h00, 8'hFF, 8'h7F, 8'h80};
        in_valid_s = 1;
        @(posedge clk); #1;
        in_valid_s = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid_s && n < 20);
        chk(out_valid_s && out_valid_u, "su_out_valid", 128'({out_valid_s, out_valid_u}), 3);
        chk(out_data_s == 32'h7F00FF80, "signed_sort", 128'(out_data_s), 128'(32'h7F00FF80));
        chk(out_data_u == 32'hFF807F00, "unsigned_sort", 128'(out_data_u), 128'(32'hFF807F00));
        chk(!out_desc_s && !out_desc_u, "su_desc", 128'({out_desc_s, out_desc_u}), 0);
        @(posedge clk); #1;

        // N=8 signed: unstalled random stream, exact latency
        strict_c = 1; out_ready_c = 1;
        repeat (80) begin
            in_valid_c = 1'($urandom_range(0, 1));
            in_data_c  = rnd128();
            in_desc_c  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid_c = 0;
        idle(10);

        // N=8 with random valid and random back-pressure
        strict_c = 0;
        n = 0;
        while (acc_c < 1000 && n < 20000) begin
            in_valid_c  = 1'($urandom_range(0, 1));
            in_data_c   = rnd128();
            in_desc_c   = 1'($urandom_range(0, 1));
            out_ready_c = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        chk(acc_c >= 1000, "accept_count_c", 128'(acc_c), 1000);
        in_valid_c = 0; out_ready_c = 1;
        n = 0;
        while ((sb_c.size() != 0 || sb_a.size() != 0) && n < 100) begin idle(1); n++; end
        idle(2);
        chk(sb_a.size() == 0, "drain_a", 128'(sb_a.size()), 0);
        chk(sb_c.size() == 0, "drain_c", 128'(sb_c.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
